// File: rtl/cnt_cmp_if.sv
// Control and status bundle for the cnt_cmp counter/compare block.
// The master drives controls and observes status; the slave is the counter.
interface cnt_cmp_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_CMP = 2
);
  logic                       en;
  logic                       clr;
  logic                       load;
  logic [WIDTH-1:0]           load_val;
  logic                       dir;
  logic                       mode;
  logic [WIDTH-1:0]           limit;
  logic [NUM_CMP*WIDTH-1:0]   cmp_val;
  logic [WIDTH-1:0]           out;
  logic [NUM_CMP-1:0]         cmp_pulse;
  logic                       wrap_pulse;
  logic                       done;

  modport master (
    output en, clr, load, load_val, dir, mode, limit, cmp_val,
    input  out, cmp_pulse, wrap_pulse, done
  );

  modport slave (
    input  en, clr, load, load_val, dir, mode, limit, cmp_val,
    output out, cmp_pulse, wrap_pulse, done
  );
endinterface

// File: rtl/cnt_cmp.sv
// Up/down counter with programmable limit, wrap or one-shot termination,
// and NUM_CMP first-match compare channels producing single-cycle pulses.
module cnt_cmp #(
  parameter int               WIDTH   = 8,
  parameter int               NUM_CMP = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  cnt_cmp_if.slave    bus,
  output logic [0:0]  o_dbg_state
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_out;
  logic [WIDTH-1:0]     w_out_nxt;
  logic                 r_wrap;
  logic                 w_wrap_nxt;
  logic [NUM_CMP-1:0]   r_match_d;
  logic [NUM_CMP-1:0]   w_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_out   <= RST_VAL;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Priority clr > load > count; S_DONE blocks counting until clr or load.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_wrap_nxt  = 1'b0;
    if (bus.clr) begin
      w_out_nxt   = '0;
      w_state_nxt = S_RUN;
    end else if (bus.load) begin
      w_out_nxt   = bus.load_val;
      w_state_nxt = S_RUN;
    end else if (bus.en && (r_state == S_RUN)) begin
      if (!bus.dir) begin
        // >= so a loaded value above limit terminates instead of running on
        if (r_out < bus.limit) begin
          w_out_nxt = r_out + 1'b1;
        end else if (!bus.mode) begin
          w_out_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end else begin
        if (r_out != '0) begin
          w_out_nxt = r_out - 1'b1;
        end else if (!bus.mode) begin
          w_out_nxt  = bus.limit;
          w_wrap_nxt = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
    end
  end

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      w_match[i] = (r_out == bus.cmp_val[i*WIDTH +: WIDTH]);
    end
  end

  // Match history resets to all-ones so a value present at reset release is not a new entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_d <= '1;
    end else begin
      r_match_d <= w_match;
    end
  end

  assign bus.out        = r_out;
  assign bus.wrap_pulse = r_wrap;
  assign bus.done       = (r_state == S_DONE);
  assign bus.cmp_pulse  = w_match & ~r_match_d;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_cnt_cmp.sv
// Bench for cnt_cmp: a reference model pushes the expected post-edge status
// into a queue as each cycle's stimulus is driven; the queue is popped after the edge.
module tb_cnt_cmp;
  localparam int W = 8;
  localparam int N = 2;
  localparam int EW = W + 2 + N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:0] dbg_state;

  cnt_cmp_if #(.WIDTH(W), .NUM_CMP(N)) bus ();

  cnt_cmp #(.WIDTH(W), .NUM_CMP(N), .RST_VAL(8'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] exp_q[$];

  logic [W-1:0] m_out;
  logic         m_done;
  logic [N-1:0] m_md;
  logic [W-1:0] m_cmp [N];

  int wrap_cnt;
  int pulse_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out  = 8'd0;
    m_done = 1'b0;
    m_md   = '1;
  endtask

  task automatic set_cmp(input logic [W-1:0] c0, input logic [W-1:0] c1);
    m_cmp[0] = c0;
    m_cmp[1] = c1;
    bus.cmp_val = {c1, c0};
  endtask

  // Drive one cycle of stimulus, predict the outcome, then compare after the edge.
  task automatic step(input logic en, input logic clr, input logic load,
                      input logic [W-1:0] lv, input logic dir, input logic mode);
    logic [W-1:0] n_out;
    logic         n_done;
    logic         n_wrap;
    logic [N-1:0] n_md;
    logic [N-1:0] n_pulse;
    logic [EW-1:0] exp_v;
    logic [EW-1:0] got_v;
    bus.en = en; bus.clr = clr; bus.load = load;
    bus.load_val = lv; bus.dir = dir; bus.mode = mode;
    n_out = m_out; n_done = m_done; n_wrap = 1'b0;
    if (clr) begin
      n_out = '0; n_done = 1'b0;
    end else if (load) begin
      n_out = lv; n_done = 1'b0;
    end else if (en && !m_done) begin
      if (!dir) begin
        if (m_out < bus.limit) n_out = m_out + 8'd1;
        else if (!mode) begin n_out = '0; n_wrap = 1'b1; end
        else n_done = 1'b1;
      end else begin
        if (m_out != 8'd0) n_out = m_out - 8'd1;
        else if (!mode) begin n_out = bus.limit; n_wrap = 1'b1; end
        else n_done = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      n_md[i]    = (m_out == m_cmp[i]);
      n_pulse[i] = (n_out == m_cmp[i]) && !n_md[i];
    end
    m_out = n_out; m_done = n_done; m_md = n_md;
    exp_q.push_back({n_out, n_wrap, n_done, n_pulse});
    @(posedge clk);
    #1;
    got_v = {bus.out, bus.wrap_pulse, bus.done, bus.cmp_pulse};
    exp_v = exp_q.pop_front();
    check("step", 32'(got_v), 32'(exp_v));
    if (bus.wrap_pulse) wrap_cnt++;
    if (bus.cmp_pulse == 2'b11) pulse_cnt++;
  endtask

  initial begin
    bus.en = 0; bus.clr = 0; bus.load = 0; bus.load_val = '0;
    bus.dir = 0; bus.mode = 0; bus.limit = 8'd9;
    set_cmp(8'd5, 8'd5);
    model_reset();
    #23;
    check("reset_out", 32'(bus.out), 32'd0);
    check("reset_flags", 32'({bus.wrap_pulse, bus.done, bus.cmp_pulse}), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 1: wrap at limit 9, 25 enabled cycles
    wrap_cnt = 0; pulse_cnt = 0;
    for (int i = 0; i < 25; i++) step(1, 0, 0, 8'd0, 0, 0);
    check("t1_wraps", 32'(wrap_cnt), 32'd2);
    check("t1_pulses", 32'(pulse_cnt), 32'd3);
    check("t1_out", 32'(bus.out), 32'd5);

    // 2: hold on 5 with en low, then one more pass
    pulse_cnt = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'd0, 0, 0);
    check("t2_hold_pulses", 32'(pulse_cnt), 32'd0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'd0, 0, 0);
    check("t2_pass_pulses", 32'(pulse_cnt), 32'd1);

    // 3: one-shot down from 3
    step(0, 1, 0, 8'd0, 1, 1);
    step(0, 0, 1, 8'd3, 1, 1);
    check("t3_load", 32'(bus.out), 32'd3);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'd0, 1, 1);
    check("t3_zero_done", 32'({bus.out, bus.done}), 32'd0);
    step(1, 0, 0, 8'd0, 1, 1);
    check("t3_done", 32'({bus.out, bus.done}), 32'd1);
    step(1, 0, 0, 8'd0, 0, 0);
    step(1, 0, 0, 8'd0, 1, 1);
    check("t3_hold", 32'({bus.out, bus.done}), 32'd1);
    step(0, 1, 0, 8'd0, 1, 1);
    check("t3_clr", 32'({bus.out, bus.done}), 32'd0);

    // 4: loaded value above limit wraps on next edge
    bus.limit = 8'd100;
    step(0, 0, 1, 8'd200, 0, 0);
    step(1, 0, 0, 8'd0, 0, 0);
    check("t4_wrap", 32'({bus.out, bus.wrap_pulse}), 32'd1);

    // 5: clr beats load, load beats count
    step(1, 1, 1, 8'd7, 0, 0);
    check("t5_clr_wins", 32'(bus.out), 32'd0);
    step(1, 0, 1, 8'd7, 0, 0);
    check("t5_load_wins", 32'(bus.out), 32'd7);

    // limit 0 wrap: stays 0, wrap every enabled cycle
    bus.limit = 8'd0; wrap_cnt = 0;
    step(0, 1, 0, 8'd0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'd0, 0, 0);
    check("lim0_wraps", 32'(wrap_cnt), 32'd3);

    // 6: async reset at out=42 with cmp0=0
    bus.limit = 8'd100;
    set_cmp(8'd0, 8'd77);
    step(0, 0, 1, 8'd40, 0, 0);
    step(1, 0, 0, 8'd0, 0, 0);
    step(1, 0, 0, 8'd0, 0, 0);
    check("t6_pre", 32'(bus.out), 32'd42);
    bus.en = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("t6_rst_out", 32'(bus.out), 32'd0);
    check("t6_rst_flags", 32'({bus.wrap_pulse, bus.done, bus.cmp_pulse}), 32'd0);
    model_reset();
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd0, 0, 0);
    check("t6_no_pulse", 32'(bus.cmp_pulse), 32'd0);
    step(0, 0, 1, 8'd3, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'd0, 1, 0);
    check("t6_repulse", 32'(bus.cmp_pulse), 32'b01);

    // random mix
    for (int i = 0; i < 80; i++) begin
      if (i % 20 == 0) begin
        bus.limit = 8'($urandom_range(0, 15));
        set_cmp(8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
      end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 11) == 0), 8'($urandom_range(0, 20)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cnt_cmp.md
Name: cnt_cmp

Overview:
Parametrised successor to the fixed 8-bit terminal-count counter. It provides a WIDTH-bit counter with enable, synchronous clear and load, and run-time up/down direction. A programmable limit sets the count range, and the counter either wraps or runs one-shot. NUM_CMP independent compare channels each emit a single-cycle pulse when the count first equals their compare value. It sits in timer/event-generation paths and drives downstream strobes.

Parameters:
WIDTH, 8, counter and compare width in bits (>=2)
NUM_CMP, 2, number of compare channels (>=1)
RST_VAL, 0, counter value on reset (WIDTH bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  count enable
clr  input  1  synchronous clear: out<=0, done<=0
load  input  1  synchronous load: out<=load_val, done<=0
load_val  input  WIDTH  load value
dir  input  1  0 = up, 1 = down
mode  input  1  0 = wrap, 1 = one-shot
limit  input  WIDTH  terminal value; count range is 0..limit
cmp_val  input  NUM_CMP*WIDTH  compare values; channel i occupies bits [i*WIDTH +: WIDTH]
out  output  WIDTH  current count (registered)
cmp_pulse  output  NUM_CMP  per-channel first-match pulse
wrap_pulse  output  1  one-cycle strobe on wrap (registered)
done  output  1  one-shot terminal reached (registered, sticky)

Behaviour:
- Reset (async, rst=1):
  - out=RST_VAL, done=0, wrap_pulse=0.
  - All match_d flags =1, so no cmp_pulse fires for a value already present when reset releases.
- Per-edge priority: clr > load > count. clr and load ignore en, dir, mode and done.
- wrap_pulse defaults to 0 each cycle. It is 1 only in the cycle following a wrap edge.
- Count step (en=1, no clr/load, done=0):
  - Up, out<limit: out+1.
  - Up, out>=limit, mode=0: out<=0, wrap_pulse<=1.
  - Up, out>=limit, mode=1: out holds, done<=1.
  - Down, out!=0: out-1.
  - Down, out==0, mode=0: out<=limit, wrap_pulse<=1.
  - Down, out==0, mode=1: out holds, done<=1.
- The terminal check uses >= in up mode. A loaded value above limit therefore wraps or terminates on the next enabled edge and never runs to 2^WIDTH-1.
- limit=0, mode=0, up: out stays 0 and wrap_pulse is high every enabled cycle.
- en=0: out, done and match state hold, and wrap_pulse returns to 0.
- done=1: counting is blocked until clr or load. done is not cleared by a dir or mode change.
- Arithmetic is modulo 2^WIDTH. No carry out beyond wrap_pulse.
- Compare channel i:
  - match_i = (out == cmp_val[i]), combinational.
  - match_d[i] is a register updated every edge with match_i (reset value 1).
  - cmp_pulse[i] = match_i & ~match_d[i], combinational from registered state, no latency from out.
  - Result: exactly one pulse per entry into the matching value, even if en stays low on it. The channel re-arms once out leaves the value.
  - A cmp_val change onto the current out produces one pulse.
  - Channels are fully independent. Equal cmp_val values pulse together.
- Direction change mid-count takes effect on the next enabled edge, with no extra cycle.
- rst asserted mid-operation clears immediately, without waiting for clk.

Test Plan:
1. WIDTH=8, limit=9, mode=0, dir=0, en=1 from reset -> out 0..9,0; wrap_pulse high exactly the cycle out==0 after 9; repeats every 10 cycles.
2. cmp_val={5,5}, run up, then en=0 while out==5 for 4 cycles -> both cmp_pulse high one cycle only at first out==5; no repeat while holding; pulse again on the next pass.
3. mode=1, dir=1, load_val=3 with load=1, then en=1 -> out 3,2,1,0; done=1 the cycle after out reaches 0 and the next enable; out holds 0; clr -> done=0, out=0.
4. Load 200 with limit=100, up, mode=0 -> next enabled edge out=0, wrap_pulse=1.
5. clr, load and en all high with load_val=7 -> out=0 (clr wins); next cycle load+en only -> out=7, no increment.
6. rst pulsed asynchronously mid-count at out=42 (RST_VAL=0, cmp_val[0]=0) -> out=0 immediately, done=0, wrap_pulse=0; no cmp_pulse[0] after release until out leaves 0 and returns.
